dijkstra_query_scheduler: RTL and testbench

Front-end sequencer for the DijkstraTop core. It queues (source, destination) queries in a small FIFO and launches them one at a time. For each query it resets and enables the core, waits for core ready, then walks the core's prev_vector from destination back to source. The path is emitted as a valid/ready node stream, with the final beat carrying a status code.

---
 rtl/dijkstra_query_scheduler.sv | 223 ++++++++++++++++++++++
 tb/tb_dijkstra_query_scheduler.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/dijkstra_query_scheduler.sv
// Query FIFO plus launch/path-walk sequencer in front of the DijkstraTop core.
// Optional DIJKSTRA_SCHED_CYCLE_COUNT_EN adds the p_cycles launch-to-ready counter.
`ifndef DEFAULT_MAX_NODES
`define DEFAULT_MAX_NODES 8
`endif
`ifndef DEFAULT_INDEX_WIDTH
`define DEFAULT_INDEX_WIDTH 4
`endif
`ifndef DEFAULT_MADDR_WIDTH
`define DEFAULT_MADDR_WIDTH 16
`endif
`ifndef NO_PREVIOUS_NODE
`define NO_PREVIOUS_NODE 15
`endif

module dijkstra_query_scheduler #(
  parameter int unsigned MAX_NODES   = `DEFAULT_MAX_NODES,
  parameter int unsigned INDEX_WIDTH = `DEFAULT_INDEX_WIDTH,
  parameter int unsigned MADDR_WIDTH = `DEFAULT_MADDR_WIDTH,
  parameter int unsigned QUEUE_DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [INDEX_WIDTH-1:0] number_of_nodes,
  input  logic [MADDR_WIDTH-1:0] base_address,
  input  logic                   q_valid,
  output logic                   q_ready,
  input  logic [INDEX_WIDTH-1:0] q_source,
  input  logic [INDEX_WIDTH-1:0] q_destination,
  output logic                   core_reset,
  output logic                   core_enable,
  output logic [INDEX_WIDTH-1:0] core_source,
  output logic [INDEX_WIDTH-1:0] core_destination,
  output logic [INDEX_WIDTH-1:0] core_number_of_nodes,
  output logic [MADDR_WIDTH-1:0] core_base_address,
  input  logic                   core_ready,
  output logic [INDEX_WIDTH-1:0] core_prev_index,
  input  logic [INDEX_WIDTH-1:0] core_prev_data,
  output logic                   p_valid,
  input  logic                   p_ready,
  output logic [INDEX_WIDTH-1:0] p_node,
  output logic                   p_last,
  output logic [1:0]             p_status,
  output logic                   busy
`ifdef DIJKSTRA_SCHED_CYCLE_COUNT_EN
  ,
  output logic [31:0]            p_cycles
`endif
);

  localparam int unsigned PTR_W = $clog2(QUEUE_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned HOP_W = INDEX_WIDTH + 1;
  localparam logic [INDEX_WIDTH-1:0] NO_PREV = INDEX_WIDTH'(`NO_PREVIOUS_NODE);

  if (QUEUE_DEPTH < 2 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("QUEUE_DEPTH must be a power of two >= 2");
  end
  if (MAX_NODES > (1 << INDEX_WIDTH)) begin : g_bad_nodes
    $error("MAX_NODES does not fit in INDEX_WIDTH");
  end

  typedef enum logic [2:0] {S_IDLE, S_CHECK, S_LAUNCH, S_RUN, S_EMIT, S_SINGLE} state_t;

  state_t                 state;
  logic [INDEX_WIDTH-1:0] fifo_src [QUEUE_DEPTH];
  logic [INDEX_WIDTH-1:0] fifo_dst [QUEUE_DEPTH];
  logic [PTR_W-1:0]       wr_ptr, rd_ptr;
  logic [CNT_W-1:0]       count, count_next;
  logic [INDEX_WIDTH-1:0] cur;
  logic [HOP_W-1:0]       hops;
  logic                   launch_cnt;
  logic [1:0]             single_status;
  logic                   push, pop, beat_done;

  assign push            = q_valid && q_ready;
  assign pop             = (state == S_IDLE) && (count != '0);
  assign count_next      = count + CNT_W'(push) - CNT_W'(pop);
  assign beat_done       = p_valid && p_ready;
  assign p_node          = cur;
  assign core_prev_index = cur;

  // Query storage needs no reset: occupancy is tracked by the pointers.
  always_ff @(posedge clock) begin
    if (push) begin
      fifo_src[wr_ptr] <= q_source;
      fifo_dst[wr_ptr] <= q_destination;
    end
  end

  // Terminal-beat decode must see prev_vector[cur] in the same cycle it is read.
  always_comb begin
    p_last   = 1'b0;
    p_status = 2'd0;
    if (state == S_SINGLE) begin
      p_last   = 1'b1;
      p_status = single_status;
    end else if (state == S_EMIT) begin
      if (cur == core_source) begin
        p_last = 1'b1;
      end else if (core_prev_data == NO_PREV) begin
        p_last   = 1'b1;
        p_status = 2'd1;
      end else if (hops == {1'b0, core_number_of_nodes}) begin
        p_last   = 1'b1;
        p_status = 2'd2;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state                <= S_IDLE;
      wr_ptr               <= '0;
      rd_ptr               <= '0;
      count                <= '0;
      q_ready              <= 1'b1;
      core_reset           <= 1'b1;
      core_enable          <= 1'b0;
      core_source          <= '0;
      core_destination     <= '0;
      core_number_of_nodes <= '0;
      core_base_address    <= '0;
      cur                  <= '0;
      hops                 <= '0;
      launch_cnt           <= 1'b0;
      single_status        <= 2'd0;
      p_valid              <= 1'b0;
      busy                 <= 1'b0;
    end else begin
      count   <= count_next;
      q_ready <= (count_next != CNT_W'(QUEUE_DEPTH));
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);

      case (state)
        S_IDLE: begin
          core_reset  <= 1'b1;
          core_enable <= 1'b0;
          if (pop) begin
            core_source          <= fifo_src[rd_ptr];
            core_destination     <= fifo_dst[rd_ptr];
            core_number_of_nodes <= number_of_nodes;
            core_base_address    <= base_address;
            busy                 <= 1'b1;
            state                <= S_CHECK;
          end
        end
        S_CHECK: begin
          cur  <= core_destination;
          hops <= '0;
          if (core_source >= core_number_of_nodes ||
              core_destination >= core_number_of_nodes) begin
            single_status <= 2'd3;
            p_valid       <= 1'b1;
            state         <= S_SINGLE;
          end else if (core_source == core_destination) begin
            single_status <= 2'd0;
            p_valid       <= 1'b1;
            state         <= S_SINGLE;
          end else begin
            core_reset <= 1'b0;
            launch_cnt <= 1'b0;
            state      <= S_LAUNCH;
          end
        end
        // Two released-reset cycles walk the core through RESET_STATE and READY_STATE.
        S_LAUNCH: begin
          if (launch_cnt) begin
            core_enable <= 1'b1;
            state       <= S_RUN;
          end else begin
            launch_cnt <= 1'b1;
          end
        end
        S_RUN: begin
          if (core_ready) begin
            core_enable <= 1'b0;
            cur         <= core_destination;
            hops        <= '0;
            p_valid     <= 1'b1;
            state       <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (beat_done) begin
            if (p_last) begin
              p_valid    <= 1'b0;
              busy       <= 1'b0;
              core_reset <= 1'b1;
              state      <= S_IDLE;
            end else begin
              cur  <= core_prev_data;
              hops <= hops + HOP_W'(1);
            end
          end
        end
        S_SINGLE: begin
          if (beat_done) begin
            p_valid <= 1'b0;
            busy    <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef DIJKSTRA_SCHED_CYCLE_COUNT_EN
  // Cleared in CHECK so rejected and trivial queries report zero.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      p_cycles <= '0;
    end else if (state == S_CHECK) begin
      p_cycles <= '0;
    end else if ((state == S_LAUNCH || state == S_RUN) && p_cycles != 32'hFFFF_FFFF) begin
      p_cycles <= p_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dijkstra_query_scheduler.sv
// Table-driven bench for dijkstra_query_scheduler with a behavioural core and beat scoreboard.
module tb_dijkstra_query_scheduler;
  localparam int unsigned IW = 4;
  localparam int unsigned MW = 16;
  localparam logic [IW-1:0] NOP = 4'd15;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [IW-1:0] number_of_nodes = 4'd4;
  logic [MW-1:0] base_address = 16'h0;
  logic          q_valid = 1'b0;
  logic          q_ready;
  logic [IW-1:0] q_source = '0;
  logic [IW-1:0] q_destination = '0;
  logic          core_reset, core_enable;
  logic [IW-1:0] core_source, core_destination, core_number_of_nodes;
  logic [MW-1:0] core_base_address;
  logic          core_ready = 1'b0;
  logic [IW-1:0] core_prev_index;
  logic [IW-1:0] core_prev_data;
  logic          p_valid;
  logic          p_ready = 1'b1;
  logic [IW-1:0] p_node;
  logic          p_last;
  logic [1:0]    p_status;
  logic          busy;
`ifdef DIJKSTRA_SCHED_CYCLE_COUNT_EN
  logic [31:0]   p_cycles;
`endif

  dijkstra_query_scheduler #(
    .MAX_NODES(8), .INDEX_WIDTH(IW), .MADDR_WIDTH(MW), .QUEUE_DEPTH(4)
  ) dut (
    .clock(clock), .reset(reset),
    .number_of_nodes(number_of_nodes), .base_address(base_address),
    .q_valid(q_valid), .q_ready(q_ready), .q_source(q_source), .q_destination(q_destination),
    .core_reset(core_reset), .core_enable(core_enable),
    .core_source(core_source), .core_destination(core_destination),
    .core_number_of_nodes(core_number_of_nodes), .core_base_address(core_base_address),
    .core_ready(core_ready), .core_prev_index(core_prev_index), .core_prev_data(core_prev_data),
    .p_valid(p_valid), .p_ready(p_ready), .p_node(p_node), .p_last(p_last),
    .p_status(p_status), .busy(busy)
`ifdef DIJKSTRA_SCHED_CYCLE_COUNT_EN
    , .p_cycles(p_cycles)
`endif
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Graphs: 0 = line 0->1->2->3, 1 = node 3 isolated, 2 = 1<->2 cycle
  int graph_sel = 0;
  function automatic logic [IW-1:0] prev_of(input int g, input logic [IW-1:0] i);
    logic [IW-1:0] r;
    r = NOP;
    case (g)
      0: case (i) 4'd1: r = 4'd0; 4'd2: r = 4'd1; 4'd3: r = 4'd2; default: r = NOP; endcase
      1: case (i) 4'd1: r = 4'd0; 4'd2: r = 4'd1; default: r = NOP; endcase
      2: case (i) 4'd1: r = 4'd2; 4'd2: r = 4'd1; default: r = NOP; endcase
      default: r = NOP;
    endcase
    return r;
  endfunction

  always_comb core_prev_data = prev_of(graph_sel, core_prev_index);

  int run_cnt = 0;
  always @(posedge clock) begin
    if (core_reset) begin
      run_cnt    <= 0;
      core_ready <= 1'b0;
    end else if (core_enable) begin
      run_cnt <= run_cnt + 1;
      if (run_cnt >= 3) core_ready <= 1'b1;
    end
  end

  bit enable_seen = 0;
  always @(negedge clock) if (core_enable) enable_seen = 1;

  bit rand_ready = 0;
  always @(posedge clock) begin
    #1;
    p_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  typedef struct packed {
    logic [IW-1:0] node;
    logic          last;
    logic [1:0]    status;
    logic          core;
  } beat_t;
  beat_t exp_q[$];

  typedef struct {
    logic [IW-1:0]       src, dst, n;
    int                  graph;
    int                  nbeats;
    logic [7:0][IW-1:0]  nodes;
    logic [1:0]          status;
    bit                  uses_core;
  } vec_t;
  vec_t vecs[10];

  function automatic vec_t mk(input logic [IW-1:0] s, d, n, input int g, input int nb,
                              input logic [31:0] nodes, input logic [1:0] st, input bit core);
    vec_t v;
    v.src = s; v.dst = d; v.n = n; v.graph = g; v.nbeats = nb;
    v.nodes = nodes; v.status = st; v.uses_core = core;
    return v;
  endfunction

  task automatic enqueue(input vec_t v);
    for (int b = 0; b < v.nbeats; b++) begin
      beat_t e;
      e.node   = v.nodes[b];
      e.last   = (b == v.nbeats - 1);
      e.status = (b == v.nbeats - 1) ? v.status : 2'd0;
      e.core   = v.uses_core;
      exp_q.push_back(e);
    end
  endtask

  // Scoreboard pop on each beat about to be accepted, plus hold check while stalled.
  beat_t      mon_e;
  bit         stalled = 0;
  logic [6:0] st_beat;
  always @(negedge clock) begin
    if (!reset) begin
      stalled = 0;
    end else begin
      if (stalled) chk("stall_hold", {p_valid, p_node, p_last, p_status}, {1'b1, st_beat});
      if (p_valid && p_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_beat", {p_node, p_last, p_status}, 32'hDEAD);
        end else begin
          mon_e = exp_q.pop_front();
          chk("beat", {p_node, p_last, p_status}, {mon_e.node, mon_e.last, mon_e.status});
`ifdef DIJKSTRA_SCHED_CYCLE_COUNT_EN
          if (mon_e.last && mon_e.status == 2'd3) chk("p_cycles_zero", p_cycles, 0);
          if (mon_e.last && mon_e.core) chk("p_cycles_nonzero", 32'(p_cycles != 0), 1);
`endif
        end
      end
      stalled = p_valid && !p_ready;
      st_beat = {p_node, p_last, p_status};
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic push(input logic [IW-1:0] s, input logic [IW-1:0] d);
    int t;
    t = 0;
    q_valid = 1'b1; q_source = s; q_destination = d;
    while (!q_ready && t < 400) begin step(); t++; end
    chk("push_accept", 32'(q_ready), 1);
    step();
    q_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int t;
    t = 0;
    while ((exp_q.size() != 0 || busy) && t < bound) begin step(); t++; end
    chk("drain_queue", exp_q.size(), 0);
    chk("drain_busy", 32'(busy), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit any_busy;
    logic [MW-1:0] base_v;
    vecs[0] = mk(4'd0, 4'd3, 4'd4, 0, 4, 32'h0123,  2'd0, 1);
    vecs[1] = mk(4'd2, 4'd2, 4'd4, 0, 1, 32'h2,     2'd0, 0);
    vecs[2] = mk(4'd0, 4'd7, 4'd4, 0, 1, 32'h7,     2'd3, 0);
    vecs[3] = mk(4'd0, 4'd3, 4'd4, 1, 1, 32'h3,     2'd1, 1);
    vecs[4] = mk(4'd1, 4'd3, 4'd4, 0, 3, 32'h123,   2'd0, 1);
    vecs[5] = mk(4'd3, 4'd0, 4'd4, 0, 1, 32'h0,     2'd1, 1);
    vecs[6] = mk(4'd0, 4'd2, 4'd4, 2, 5, 32'h21212, 2'd2, 1);
    vecs[7] = mk(4'd4, 4'd1, 4'd4, 0, 1, 32'h1,     2'd3, 0);
    vecs[8] = mk(4'd0, 4'd3, 4'd3, 0, 1, 32'h3,     2'd3, 0);
    vecs[9] = mk(4'd0, 4'd3, 4'd8, 0, 4, 32'h0123,  2'd0, 1);

    repeat (3) step();
    chk("rst_q_ready", 32'(q_ready), 1);
    chk("rst_core_ctl", {core_reset, core_enable}, 2'b10);
    chk("rst_path", {p_valid, p_last, p_status, p_node}, 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_latched", {core_source, core_destination, core_number_of_nodes, core_base_address}, 0);
    reset = 1'b1;
    step();

    for (int i = 0; i < 10; i++) begin
      graph_sel       = vecs[i].graph;
      number_of_nodes = vecs[i].n;
      base_v          = 16'h1000 + MW'(i);
      base_address    = base_v;
      enable_seen     = 0;
      enqueue(vecs[i]);
      push(vecs[i].src, vecs[i].dst);
      if (vecs[i].uses_core) begin
        lat = 0;
        while (!core_enable && lat < 20) begin step(); lat++; end
        chk("enable_latency", lat, 4);
        chk("latched", {core_source, core_destination, core_number_of_nodes, core_base_address},
            {vecs[i].src, vecs[i].dst, vecs[i].n, base_v});
        lat = 0;
        while (!core_ready && lat < 50) begin step(); lat++; end
        step();
        chk("first_beat_latency", 32'(p_valid), 1);
      end
      wait_idle(500);
      chk("core_used", 32'(enable_seen), 32'(vecs[i].uses_core));
    end

    // Back-to-back burst with a stalling sink
    graph_sel = 0; number_of_nodes = 4'd4; rand_ready = 1;
    enqueue(vecs[0]); push(vecs[0].src, vecs[0].dst);
    enqueue(vecs[4]); push(vecs[4].src, vecs[4].dst);
    enqueue(vecs[1]); push(vecs[1].src, vecs[1].dst);
    enqueue(vecs[2]); push(vecs[2].src, vecs[2].dst);
    enqueue(vecs[5]); push(vecs[5].src, vecs[5].dst);
    chk("q_ready_full", 32'(q_ready), 0);
    chk("busy_burst", 32'(busy), 1);
    enqueue(vecs[7]); push(vecs[7].src, vecs[7].dst);
    wait_idle(3000);
    rand_ready = 0;

    // Reset while the core is running, with queries still buffered
    push(4'd0, 4'd3);
    push(4'd1, 4'd3);
    push(4'd2, 4'd2);
    lat = 0;
    while (!core_enable && lat < 40) begin step(); lat++; end
    chk("reached_run", 32'(core_enable), 1);
    reset = 1'b0;
    #1;
    chk("abort_core_ctl", {core_reset, core_enable}, 2'b10);
    chk("abort_path", {p_valid, busy, q_ready}, 3'b001);
    step(); step();
    reset = 1'b1;
    any_busy = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (busy || p_valid) any_busy = 1;
    end
    chk("fifo_flushed", 32'(any_busy), 0);
    enqueue(vecs[0]);
    push(vecs[0].src, vecs[0].dst);
    wait_idle(500);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
